// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard-controller state encoding, ctrl_MEM bit
// positions and register-number constants.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_TRAP = 2'd3
  } state_e;

  // Bit positions inside the ctrl_MEM control bundle
  localparam int CTRL_MEM_MEMREAD = 0;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_detect.sv
// Load-use comparator: the load in EX writes a register that the ID
// instruction reads. Register zero never produces a hazard.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic       mem_read_exe,
  input  logic [4:0] rt_exe,
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic       use_rs,
  input  logic       use_rt,
  output logic       lu
);

  logic rs_hit;
  logic rt_hit;

  // Operand match against the load destination
  always_comb begin
    rs_hit = use_rs && (rs_id == rt_exe);
    rt_hit = use_rt && (rt_id == rt_exe);
    lu     = mem_read_exe && (rt_exe != REG_ZERO) && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, branch/jump redirects,
// data-memory freeze with timeout watchdog, and stall/redirect statistics.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             reloj,
  input  logic             reset,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic             mem_read_exe,
  input  logic [4:0]       rt_exe,
  input  logic             jump_id,
  input  logic             branch_taken_exe,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_flush,
  output logic [1:0]       state,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              lu;
  logic              mw;
  logic              redirect;

  hazard_detect u_detect (
    .mem_read_exe (mem_read_exe),
    .rt_exe       (rt_exe),
    .rs_id        (rs_id),
    .rt_id        (rt_id),
    .use_rs       (use_rs),
    .use_rt       (use_rt),
    .lu           (lu)
  );

  assign mw = mem_req && !mem_ready;

  // Next-state, watchdog and stage-control outputs
  always_comb begin
    pc_we         = 1'b1;
    ifid_we       = 1'b1;
    idex_we       = 1'b1;
    exmem_we      = 1'b1;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    memwb_flush   = 1'b0;
    redirect      = 1'b0;
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;

    if (reset) begin
      pc_we         = 1'b0;
      ifid_we       = 1'b0;
      idex_we       = 1'b0;
      exmem_we      = 1'b0;
      ifid_flush    = 1'b1;
      idex_flush    = 1'b1;
      memwb_flush   = 1'b1;
      state_d       = ST_RUN;
      wait_cnt_d    = {WAIT_W{1'b0}};
      mem_timeout_d = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          // Memory wait outranks everything: held inputs are re-evaluated later
          if (mw) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_we    = 1'b0;
            memwb_flush = 1'b1;
            state_d     = ST_WAIT;
            wait_cnt_d  = WAIT_W'(1);
          end else if (branch_taken_exe) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            redirect   = 1'b1;
          end else if (lu) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
          end else if (jump_id) begin
            ifid_flush = 1'b1;
            redirect   = 1'b1;
          end else begin
            redirect = 1'b0;
          end
        end
        ST_WAIT: begin
          if (mem_ready) begin
            state_d    = ST_RUN;
            wait_cnt_d = {WAIT_W{1'b0}};
          end else begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_we    = 1'b0;
            memwb_flush = 1'b1;
            if (wait_cnt_q >= WAIT_W'(TIMEOUT)) begin
              state_d       = ST_TRAP;
              mem_timeout_d = 1'b1;
            end else begin
              wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
          end
        end
        ST_TRAP: begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_we     = 1'b0;
          exmem_we    = 1'b0;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          memwb_flush = 1'b1;
        end
        default: begin
          // Unreachable encoding: hold the pipe and recover to RUN
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_we     = 1'b0;
          exmem_we    = 1'b0;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          memwb_flush = 1'b1;
          state_d     = ST_RUN;
          wait_cnt_d  = {WAIT_W{1'b0}};
        end
      endcase
    end
  end

  // Saturating statistics counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (reset) begin
      stall_cnt_d = {CNT_W{1'b0}};
      flush_cnt_d = {CNT_W{1'b0}};
    end else begin
      if (((state_q == ST_RUN) || (state_q == ST_WAIT)) && !pc_we && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
      if (redirect && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else begin
        flush_cnt_d = flush_cnt_q;
      end
    end
  end

  // State and statistics registers; reset values come through the _d logic
  always_ff @(posedge reloj) begin
    state_q       <= state_d;
    wait_cnt_q    <= wait_cnt_d;
    mem_timeout_q <= mem_timeout_d;
    stall_cnt_q   <= stall_cnt_d;
    flush_cnt_q   <= flush_cnt_d;
  end

  assign state       = state_q;
  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: each driven cycle pushes its expected
// outputs, which are popped and compared mid-cycle on the falling edge.
module tb_hazard_ctrl;

  logic        reloj;
  logic        reset;
  logic [4:0]  rs_id, rt_id, rt_exe;
  logic        use_rs, use_rt, mem_read_exe;
  logic        jump_id, branch_taken_exe, mem_req, mem_ready;
  logic        pc_we, ifid_we, ifid_flush, idex_flush, idex_we, exmem_we, memwb_flush;
  logic [1:0]  state;
  logic        mem_timeout;
  logic [15:0] stall_cnt, flush_cnt;

  typedef struct packed {
    logic [6:0]  outs;
    logic [1:0]  st;
    logic        to;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // {pc_we, ifid_we, ifid_flush, idex_flush, idex_we, exmem_we, memwb_flush}
  localparam logic [6:0] O_NORM = 7'b1100110;
  localparam logic [6:0] O_RST  = 7'b0011001;
  localparam logic [6:0] O_FRZ  = 7'b0000001;
  localparam logic [6:0] O_BR   = 7'b1111110;
  localparam logic [6:0] O_LU   = 7'b0001110;
  localparam logic [6:0] O_JMP  = 7'b1110110;
  localparam logic [6:0] O_TRAP = 7'b0011001;

  hazard_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut (
    .reloj            (reloj),
    .reset            (reset),
    .rs_id            (rs_id),
    .rt_id            (rt_id),
    .use_rs           (use_rs),
    .use_rt           (use_rt),
    .mem_read_exe     (mem_read_exe),
    .rt_exe           (rt_exe),
    .jump_id          (jump_id),
    .branch_taken_exe (branch_taken_exe),
    .mem_req          (mem_req),
    .mem_ready        (mem_ready),
    .pc_we            (pc_we),
    .ifid_we          (ifid_we),
    .ifid_flush       (ifid_flush),
    .idex_flush       (idex_flush),
    .idex_we          (idex_we),
    .exmem_we         (exmem_we),
    .memwb_flush      (memwb_flush),
    .state            (state),
    .mem_timeout      (mem_timeout),
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt)
  );

  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs after the edge, push expectation, compare at negedge
  task automatic cyc(input string tag, input logic r,
                     input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                     input logic mre, input logic [4:0] rte,
                     input logic jmp, input logic br, input logic mreq, input logic mrdy,
                     input logic [6:0] eo, input logic [1:0] es, input logic eto,
                     input int esc, input int efc);
    exp_t e;
    reset = r; rs_id = rs; rt_id = rt; use_rs = urs; use_rt = urt;
    mem_read_exe = mre; rt_exe = rte; jump_id = jmp; branch_taken_exe = br;
    mem_req = mreq; mem_ready = mrdy;
    exp_q.push_back('{outs: eo, st: es, to: eto, sc: 16'(esc), fc: 16'(efc)});
    @(negedge reloj);
    if (exp_q.size() == 0) begin
      check_eq({tag, ".queue"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, ".outs"}, int'({pc_we, ifid_we, ifid_flush, idex_flush, idex_we, exmem_we, memwb_flush}), int'(e.outs));
      check_eq({tag, ".state"}, int'(state), int'(e.st));
      check_eq({tag, ".timeout"}, int'(mem_timeout), int'(e.to));
      check_eq({tag, ".stall_cnt"}, int'(stall_cnt), int'(e.sc));
      check_eq({tag, ".flush_cnt"}, int'(flush_cnt), int'(e.fc));
    end
    @(posedge reloj);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; rs_id = 5'd0; rt_id = 5'd0; use_rs = 1'b0; use_rt = 1'b0;
    mem_read_exe = 1'b0; rt_exe = 5'd0; jump_id = 1'b0; branch_taken_exe = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
    @(posedge reloj);
    #1;
    //        tag          rst rs    rt    urs   urt   mre   rte   jmp   br    mreq  mrdy  outs    st     to    sc  fc
    cyc("rst",         1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_RST,  2'd0, 1'b0, 0,  0);
    cyc("first_run",   1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM, 2'd0, 1'b0, 0,  0);
    cyc("lu_rs",       1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, O_LU,   2'd0, 1'b0, 0,  0);
    cyc("lu_clear",    1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM, 2'd0, 1'b0, 1,  0);
    cyc("lu_r0",       1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM, 2'd0, 1'b0, 1,  0);
    cyc("lu_nouse",    1'b0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM, 2'd0, 1'b0, 1,  0);
    cyc("lu_rt",       1'b0, 5'd0, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, O_LU,   2'd0, 1'b0, 1,  0);
    cyc("br_over_lu",  1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, O_BR,   2'd0, 1'b0, 2,  0);
    cyc("jump",        1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_JMP,  2'd0, 1'b0, 2,  1);
    cyc("idle",        1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM, 2'd0, 1'b0, 2,  2);
    cyc("mw_1",        1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_FRZ,  2'd0, 1'b0, 2,  2);
    cyc("mw_2",        1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_FRZ,  2'd1, 1'b0, 3,  2);
    cyc("mw_3",        1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_FRZ,  2'd1, 1'b0, 4,  2);
    cyc("mw_ready",    1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, O_NORM, 2'd1, 1'b0, 5,  2);
    cyc("mw_done",     1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM, 2'd0, 1'b0, 5,  2);
    cyc("to_run",      1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, O_FRZ,  2'd0, 1'b0, 5,  2);
    for (int i = 0; i < 4; i++) begin
      cyc($sformatf("to_wait%0d", i + 1), 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0,
          O_FRZ, 2'd1, 1'b0, 6 + i, 2);
    end
    cyc("trap",        1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, O_TRAP, 2'd3, 1'b1, 10, 2);
    cyc("trap_hold",   1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, O_TRAP, 2'd3, 1'b1, 10, 2);
    cyc("trap_rst",    1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_RST,  2'd3, 1'b1, 10, 2);
    cyc("post_trap",   1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM, 2'd0, 1'b0, 0,  0);
    cyc("wr_1",        1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_FRZ,  2'd0, 1'b0, 0,  0);
    cyc("wr_2",        1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_FRZ,  2'd1, 1'b0, 1,  0);
    cyc("wait_rst",    1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_RST,  2'd1, 1'b0, 2,  0);
    cyc("post_wait",   1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM, 2'd0, 1'b0, 0,  0);
    check_eq("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
